cordic_octant_fold: RTL and testbench
=====================================

# cordic_octant_fold

Full-circle front/back end for the pipelined `cordic` core. It accepts an unsigned phase covering 0..2π and folds it into a first-octant residual, which it issues to the core with `in_x = K` and `in_y = 0`. It tracks each sample's octant in order alongside the core's fixed-latency pipeline, then unfolds the core's quadrant-I result into signed cos/sin. Results are buffered behind a valid/ready handshake. The core sits between this block's `core_*` ports; this block never stalls it.

## Interface
- `BIT_WIDTH`, 16, width of phase, core operands and results
- `K`, 16'h4DBA, CORDIC gain compensation driven on `core_x` (0.60725·2^(BIT_WIDTH-1))
- `DEPTH`, 32, tag/result buffer depth; must be ≥ core latency + 2
- `clk`  input  1  single clock; all logic on rising edge
- `reset`  input  1  synchronous, active-low; tie the core's active-high reset to `~reset`
- `in_phase`  input  BIT_WIDTH  unsigned phase; value p means 2π·p/2^BIT_WIDTH
- `in_valid` / `in_ready`  input / output  1  upstream handshake
- `core_start`  output  1  one-cycle issue strobe to core
- `core_angle`, `core_x`, `core_y`  output  BIT_WIDTH  core operands (signed)
- `core_out_x`, `core_out_y`  input  BIT_WIDTH  core results (≥ 0)
- `core_done`  input  1  one pulse per issued sample, in issue order
- `out_cos`, `out_sin`  output  BIT_WIDTH  signed Q1.(BIT_WIDTH-1) results
- `out_valid` / `out_ready`  output / input  1  downstream handshake
- `tag_err`  output  1  sticky: `core_done` seen with tag FIFO empty

## Operation
- Accept occurs when `in_valid & in_ready`.
- On accept, the octant is `o = in_phase[W-1:W-3]` and the residual is `r = in_phase[W-4:0]`.
- Folded residual: `φ = r` when `o[0] == 0`, otherwise `φ = ~r`. The odd-octant mirror is off by 1 LSB; this is accepted.
- `core_angle = {1'b0, φ, 2'b00}`, which lies in 0..2^(W-1)-4 (0..π/4). `core_x = K`, `core_y = 0`, both held constant.
- Tag FIFO (3-bit entries, DEPTH entries): push `o` on accept; pop on `core_done`.
- Unfold with `c = core_out_x`, `s = core_out_y`, `o` = popped tag:
  - swap when `o[1]^o[0]`: cos←s, sin←c.
  - negate cos when `o[2]^o[1]`.
  - negate sin when `o[2]`.
- Negation is two's complement. Core results are never the minimum negative value, so negation cannot overflow.
- Result FIFO (2·BIT_WIDTH wide, DEPTH entries): push the unfolded pair one cycle after `core_done`; pop on `out_valid & out_ready`.
- Credit rule: `inflight` counts issued samples not yet pushed to the result FIFO. `in_ready = reset & (inflight + result_count < DEPTH)`. Core output can therefore never overflow the result FIFO.
- Simultaneous accept, core return and output pop in the same cycle must leave all counters exact (net ±1 or 0).
- `core_done` with the tag FIFO empty: the result is dropped and `tag_err` is set. `tag_err` clears only on reset.

## Timing
- Cycle 0: accept. Cycle 1: `core_start = 1` with `core_angle` registered.
- Core latency is L = BIT_WIDTH cycles, so `core_done` arrives at cycle 1+L.
- Cycle 2+L: the result is in the FIFO and `out_valid = 1` with `out_ready` high. Minimum latency is 2+L.
- Throughput is one sample per cycle while credits remain. `out_ready` low for DEPTH cycles drops `in_ready`.
- `out_cos` / `out_sin` are stable while `out_valid & ~out_ready`.
- Reset values:
  - `in_ready = 0` while reset is low.
  - `out_valid = 0`, `core_start = 0`, `core_angle = 0`, `out_cos = out_sin = 0`, `tag_err = 0`.
  - Both FIFOs are empty and `inflight = 0`.
- Reset mid-operation: in-flight samples are discarded. The first accept after reset release is issued normally.

## Structure
- Package `cordic_pkg` holds:
  - `octant_t` (logic [2:0]).
  - Functions `fold_angle` and `unfold_result`.
  - `K` default constant, shared with the core's generator.
- Sub-module `cordic_sync_fifo` (parameterised width/depth, synchronous active-low reset, count output) is instantiated twice: tag FIFO and result FIFO.
- Issue register, credit counter and unfold register live in the top.

## Test plan
- Phase 16'h0000 → `core_angle = 0`; `out_cos ≈ 16'h7FFF`, `out_sin ≈ 0` (±4 LSB) at cycle 18.
- Phase 16'h4000 (π/2, o=2) → `core_angle = 0`; `out_cos ≈ 0`, `out_sin ≈ 16'h7FFF`.
- Phase 16'h2000 (o=1, r=0) → `core_angle = 16'h7FFC`; `out_cos ≈ out_sin ≈ 16'h5A82`.
- Phase 16'hA000 (o=5) → `out_cos ≈ out_sin ≈ 16'hA57E`; sweep all 8 octants against a real-valued model (±4 LSB).
- Back-to-back stream of 100 phases with random `out_ready` (30% low) and DEPTH=20:
  - `in_ready` deasserts exactly at 20 outstanding.
  - Outputs appear in order with no drops or duplicates.
- Drive reset low while 10 samples are in flight:
  - all outputs take their reset values the next cycle.
  - No stale result appears after release.
  - A spurious `core_done` injected with the FIFO empty sets `tag_err` and produces no output.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared types, gain constant and octant fold/unfold helpers for the
// full-circle front/back end around the pipelined cordic core.
package cordic_pkg;

    localparam int                  CORDIC_W  = 16;
    localparam logic [CORDIC_W-1:0] K_DEFAULT = 16'h4DBA;

    typedef logic [2:0] octant_t;

    typedef struct packed {
        logic [CORDIC_W-1:0] cos_v;
        logic [CORDIC_W-1:0] sin_v;
    } trig_pair_t;

    function automatic logic [CORDIC_W-1:0] negate(input logic [CORDIC_W-1:0] v);
        return {CORDIC_W{1'b0}} - v;
    endfunction

    // Odd octants mirror the residual with ~r, one LSB short of the exact mirror.
    function automatic logic [CORDIC_W-1:0] fold_angle(input logic [CORDIC_W-1:0] phase);
        octant_t             oct;
        logic [CORDIC_W-4:0] res;
        logic [CORDIC_W-4:0] phi;
        oct = phase[CORDIC_W-1 -: 3];
        res = phase[CORDIC_W-4:0];
        if (oct[0]) begin
            phi = ~res;
        end else begin
            phi = res;
        end
        return {1'b0, phi, 2'b00};
    endfunction

    function automatic trig_pair_t unfold_result(
        input octant_t             oct,
        input logic [CORDIC_W-1:0] c,
        input logic [CORDIC_W-1:0] s
    );
        trig_pair_t p;
        if (oct[1] ^ oct[0]) begin
            p.cos_v = s;
            p.sin_v = c;
        end else begin
            p.cos_v = c;
            p.sin_v = s;
        end
        if (oct[2] ^ oct[1]) begin
            p.cos_v = negate(p.cos_v);
        end else begin
            p.cos_v = p.cos_v;
        end
        if (oct[2]) begin
            p.sin_v = negate(p.sin_v);
        end else begin
            p.sin_v = p.sin_v;
        end
        return p;
    endfunction

endpackage

// File: rtl/cordic_sync_fifo.sv
// Synchronous FIFO with occupancy count; head data reads as zero while empty
// so consumers see clean values straight out of reset.
module cordic_sync_fifo #(
    parameter int  WIDTH = 8,
    parameter int  DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             empty_s;
    logic             full_s;
    logic             push_ok_s;
    logic             pop_ok_s;

    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
        if (p == AW'(DEPTH - 1)) begin
            return '0;
        end else begin
            return p + AW'(1);
        end
    endfunction

    assign empty_s   = (count_r == '0);
    assign full_s    = (count_r == CW'(DEPTH));
    assign push_ok_s = push & ~full_s;
    assign pop_ok_s  = pop & ~empty_s;
    assign count     = count_r;
    assign dout      = empty_s ? '0 : mem_r[rd_ptr_r];

    // Storage array; no reset needed because dout is masked while empty.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave count unchanged.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= ptr_next(wr_ptr_r);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= ptr_next(rd_ptr_r);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/cordic_octant_fold.sv
// Full-circle wrapper for the pipelined cordic core: folds the phase into the
// first octant on issue and unfolds the returned pair into signed cos/sin.
module cordic_octant_fold
    import cordic_pkg::*;
#(
    parameter int                   BIT_WIDTH = CORDIC_W,
    parameter logic [BIT_WIDTH-1:0] K         = K_DEFAULT,
    parameter int                   DEPTH     = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BIT_WIDTH-1:0] in_phase,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 core_start,
    output logic [BIT_WIDTH-1:0] core_angle,
    output logic [BIT_WIDTH-1:0] core_x,
    output logic [BIT_WIDTH-1:0] core_y,
    input  logic [BIT_WIDTH-1:0] core_out_x,
    input  logic [BIT_WIDTH-1:0] core_out_y,
    input  logic                 core_done,
    output logic [BIT_WIDTH-1:0] out_cos,
    output logic [BIT_WIDTH-1:0] out_sin,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 tag_err
);
    localparam int             CW        = $clog2(DEPTH + 1);
    localparam int             SW        = CW + 1;
    localparam logic [CW:0]    DEPTH_LIM = SW'(DEPTH);

    logic                   accept_s;
    logic                   ret_ok_s;
    logic                   tag_empty_s;
    logic [CW-1:0]          tag_count_s;
    octant_t                tag_head_s;
    logic [CW-1:0]          res_count_s;
    logic [2*BIT_WIDTH-1:0] res_head_s;
    trig_pair_t             unfold_s;
    logic [CW:0]            credit_sum_s;
    logic [CW-1:0]          inflight_r;
    logic                   core_start_r;
    logic [BIT_WIDTH-1:0]   core_angle_r;
    logic                   tag_err_r;

    assign accept_s     = in_valid & in_ready;
    assign tag_empty_s  = (tag_count_s == '0);
    assign ret_ok_s     = core_done & ~tag_empty_s;
    // Credits cover both samples still in the core and results not yet drained,
    // so a core return always finds room in the result FIFO.
    assign credit_sum_s = {1'b0, inflight_r} + {1'b0, res_count_s};
    assign in_ready     = reset & (credit_sum_s < DEPTH_LIM);

    assign core_start = core_start_r;
    assign core_angle = core_angle_r;
    assign core_x     = K;
    assign core_y     = '0;
    assign tag_err    = tag_err_r;

    cordic_sync_fifo #(
        .WIDTH (3),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk   (clk),
        .rst_n (reset),
        .push  (accept_s),
        .din   (in_phase[BIT_WIDTH-1 -: 3]),
        .pop   (core_done),
        .dout  (tag_head_s),
        .count (tag_count_s)
    );

    assign unfold_s = unfold_result(tag_head_s, core_out_x, core_out_y);

    cordic_sync_fifo #(
        .WIDTH (2 * BIT_WIDTH),
        .DEPTH (DEPTH)
    ) u_res_fifo (
        .clk   (clk),
        .rst_n (reset),
        .push  (ret_ok_s),
        .din   (unfold_s),
        .pop   (out_ready),
        .dout  (res_head_s),
        .count (res_count_s)
    );

    assign out_valid = (res_count_s != '0);
    assign out_cos   = res_head_s[2*BIT_WIDTH-1:BIT_WIDTH];
    assign out_sin   = res_head_s[BIT_WIDTH-1:0];

    // Issue stage: strobe the core the cycle after accept with the folded angle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            core_start_r <= 1'b0;
            core_angle_r <= '0;
        end else begin
            core_start_r <= accept_s;
            if (accept_s) begin
                core_angle_r <= fold_angle(in_phase);
            end else begin
                core_angle_r <= core_angle_r;
            end
        end
    end

    // Samples issued but not yet written to the result FIFO.
    always_ff @(posedge clk) begin
        if (!reset) begin
            inflight_r <= '0;
        end else begin
            case ({accept_s, ret_ok_s})
                2'b10:   inflight_r <= inflight_r + CW'(1);
                2'b01:   inflight_r <= inflight_r - CW'(1);
                default: inflight_r <= inflight_r;
            endcase
        end
    end

    // Sticky flag for a core return with no matching octant tag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tag_err_r <= 1'b0;
        end else if (core_done & tag_empty_s) begin
            tag_err_r <= 1'b1;
        end else begin
            tag_err_r <= tag_err_r;
        end
    end

endmodule

// File: tb/tb_cordic_octant_fold.sv
// Scoreboard bench for cordic_octant_fold with an ideal fixed-latency core model
// and a real-valued cos/sin reference computed from the phase.
`timescale 1ns/1ps
module tb_cordic_octant_fold;

    localparam int  W     = 16;
    localparam int  DEPTH = 20;
    localparam int  L     = 16;
    localparam int  LAT   = 18;
    localparam real PI    = 3.14159265358979323846;
    localparam real TOL   = 4.0;

    typedef struct {
        logic [W-1:0] ph;
        real          c;
        real          s;
        int           acc;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] in_phase;
    logic         in_valid;
    logic         in_ready;
    logic         core_start;
    logic [W-1:0] core_angle;
    logic [W-1:0] core_x;
    logic [W-1:0] core_y;
    logic [W-1:0] core_out_x;
    logic [W-1:0] core_out_y;
    logic         core_done;
    logic [W-1:0] out_cos;
    logic [W-1:0] out_sin;
    logic         out_valid;
    logic         out_ready;
    logic         tag_err;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    exp_t q[$];
    logic rst_at_edge = 1'b0;
    logic prev_acc    = 1'b0;
    logic [W-1:0] prev_ang = '0;
    logic hold_r = 1'b0;
    logic [W-1:0] hold_cos = '0;
    logic [W-1:0] hold_sin = '0;
    bit   lat_check = 1'b1;
    bit   saw_full  = 1'b0;

    always #5 clk = ~clk;

    cordic_octant_fold #(
        .BIT_WIDTH (W),
        .K         (16'h4DBA),
        .DEPTH     (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_phase   (in_phase),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .core_start (core_start),
        .core_angle (core_angle),
        .core_x     (core_x),
        .core_y     (core_y),
        .core_out_x (core_out_x),
        .core_out_y (core_out_y),
        .core_done  (core_done),
        .out_cos    (out_cos),
        .out_sin    (out_sin),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .tag_err    (tag_err)
    );

    // ---------------- ideal core: angle full scale 2^15 spans 0..pi/4 -------------
    logic [L-1:0] pv = '0;
    logic [W-1:0] px [L];
    logic [W-1:0] py [L];
    logic         inject_done;
    logic [W-1:0] inj_x;
    logic [W-1:0] inj_y;

    function automatic logic [W-1:0] core_ideal(input logic [W-1:0] ang, input bit want_sin);
        real th;
        int  v;
        th = real'(ang) * PI / 131072.0;
        v  = $rtoi((want_sin ? $sin(th) : $cos(th)) * 32767.0 + 0.5);
        return W'(v);
    endfunction

    assign core_done  = pv[L-1] | inject_done;
    assign core_out_x = inject_done ? inj_x : px[L-1];
    assign core_out_y = inject_done ? inj_y : py[L-1];

    always @(posedge clk) begin
        if (!reset) begin
            pv <= '0;
        end else begin
            pv    <= {pv[L-2:0], core_start};
            px[0] <= core_ideal(core_angle, 1'b0);
            py[0] <= core_ideal(core_angle, 1'b1);
            for (int i = 1; i < L; i++) begin
                px[i] <= px[i-1];
                py[i] <= py[i-1];
            end
        end
    end

    // ---------------- reference model -------------------------------------------
    // Odd octants fold with ~r, which lands one phase LSB further round the circle.
    function automatic real ref_trig(input logic [W-1:0] ph, input bit want_sin);
        int  p;
        real th;
        p  = int'(ph);
        if (((p / 8192) % 2) == 1) p = p + 1;
        th = 2.0 * PI * real'(p) / 65536.0;
        return (want_sin ? $sin(th) : $cos(th)) * 32767.0;
    endfunction

    function automatic logic [W-1:0] ref_angle(input logic [W-1:0] ph);
        int p;
        int r;
        p = int'(ph);
        r = p % 8192;
        if (((p / 8192) % 2) == 1) r = 8191 - r;
        return W'(r * 4);
    endfunction

    function automatic real rabs(input real v);
        return (v < 0.0) ? -v : v;
    endfunction

    task automatic check(input bit ok, input string name, input int act, input int req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rst_at_edge <= reset;
    end

    // ---------------- monitor / scoreboard --------------------------------------
    always @(negedge clk) begin
        exp_t e;
        real  rc;
        real  rs;
        if (!rst_at_edge) begin
            check(!out_valid && !core_start && core_angle == '0 && out_cos == '0 &&
                  out_sin == '0 && !tag_err, "reset_values",
                  int'({out_valid, core_start, tag_err}), 0);
        end
        if (!reset) begin
            check(!in_ready, "in_ready_in_reset", int'(in_ready), 0);
            q.delete();
            prev_acc <= 1'b0;
            hold_r   <= 1'b0;
        end else begin
            check(in_ready == (q.size() < DEPTH), "in_ready_credit", int'(in_ready), int'(q.size() < DEPTH));
            if (!in_ready && q.size() == DEPTH) saw_full = 1'b1;
            check(core_start == prev_acc, "core_start", int'(core_start), int'(prev_acc));
            if (prev_acc) check(core_angle == prev_ang, "core_angle", int'(core_angle), int'(prev_ang));
            check(!out_valid || q.size() != 0, "spurious_out_valid", int'(out_valid), 0);
            if (hold_r && rst_at_edge) begin
                check(out_valid && out_cos == hold_cos && out_sin == hold_sin, "hold_stable",
                      int'(out_cos), int'(hold_cos));
            end
            if (out_valid && out_ready && q.size() != 0) begin
                e  = q.pop_front();
                rc = real'($signed(out_cos));
                rs = real'($signed(out_sin));
                checks++;
                if (rabs(rc - e.c) > TOL) begin
                    failures++;
                    $display("FAIL cos phase=%h actual=%0d required=%0d", e.ph, $signed(out_cos), $rtoi(e.c));
                end
                checks++;
                if (rabs(rs - e.s) > TOL) begin
                    failures++;
                    $display("FAIL sin phase=%h actual=%0d required=%0d", e.ph, $signed(out_sin), $rtoi(e.s));
                end
                if (lat_check) check(cyc - e.acc == LAT, "latency", cyc - e.acc, LAT);
            end
            hold_r   <= out_valid && !out_ready;
            hold_cos <= out_cos;
            hold_sin <= out_sin;
            prev_acc <= in_valid && in_ready;
            if (in_valid && in_ready) begin
                prev_ang <= ref_angle(in_phase);
                e.ph  = in_phase;
                e.c   = ref_trig(in_phase, 1'b0);
                e.s   = ref_trig(in_phase, 1'b1);
                e.acc = cyc;
                q.push_back(e);
            end
        end
    end

    // ---------------- stimulus ---------------------------------------------------
    task automatic wait_drain(input int bound);
        int n;
        n = 0;
        while (q.size() != 0 && n < bound) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        check(q.size() == 0, "drain_timeout", q.size(), 0);
        #1;
    endtask

    task automatic send_one(input logic [W-1:0] ph);
        int n;
        n = 0;
        @(posedge clk);
        #1;
        while (!in_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(in_ready, "in_ready_timeout", int'(in_ready), 1);
        in_valid = 1'b1;
        in_phase = ph;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_drain(60);
    endtask

    task automatic stream(input int n_samples);
        int sent;
        int guard;
        bit acc;
        sent  = 0;
        guard = 0;
        @(posedge clk);
        #1;
        in_phase = W'($urandom);
        while (sent < n_samples && guard < 5000) begin
            in_valid  = 1'b1;
            out_ready = (guard >= 40 && guard < 70) ? 1'b0 : ($urandom_range(0, 99) >= 30);
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                sent++;
                in_phase = W'($urandom);
            end
            guard++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check(sent == n_samples, "stream_timeout", sent, n_samples);
    endtask

    initial begin
        logic [W-1:0] dir_ph [4];
        dir_ph = '{16'h0000, 16'h4000, 16'h2000, 16'hA000};
        reset       = 1'b0;
        in_valid    = 1'b0;
        in_phase    = '0;
        out_ready   = 1'b1;
        inject_done = 1'b0;
        inj_x       = '0;
        inj_y       = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        check(core_x == 16'h4DBA && core_y == '0, "core_operands", int'(core_x), 16'h4DBA);

        for (int i = 0; i < 4; i++) send_one(dir_ph[i]);
        for (int o = 0; o < 8; o++) send_one(W'(o * 8192 + $urandom_range(0, 8191)));

        lat_check = 1'b0;
        stream(100);
        wait_drain(300);
        check(saw_full, "credit_limit_reached", int'(saw_full), 1);

        // Ten samples in flight, then reset mid-operation.
        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_phase = W'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (40) @(posedge clk);
        #1;

        inject_done = 1'b1;
        inj_x       = 16'h1234;
        inj_y       = 16'h0567;
        @(posedge clk);
        #1;
        inject_done = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check(tag_err, "tag_err_set", int'(tag_err), 1);
            check(!out_valid, "no_out_after_spurious", int'(out_valid), 0);
        end

        lat_check = 1'b1;
        send_one(16'h6000);
        send_one(16'hE123);
        check(tag_err, "tag_err_sticky", int'(tag_err), 1);

        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check(!tag_err, "tag_err_cleared", int'(tag_err), 0);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
